vrc_reg_decode: RTL

- Upstream front-end for the VRC2/VRC4/VRC6 family (mappers 21–26): samples the raw CPU bus on the fast system clock, filters M2, and decodes each qualified CPU write to $8000–$FFFF into a canonical register address of the form $X000..$X003, plus data and a one-cycle write strobe.
- Removes per-variant address-line swizzling before the register bank and the VRC IRQ counter, so those consume a single uniform register map.

---
 rtl/vrc_pkg.sv | 59 +++++
 rtl/vrc_reg_decode_m2_sync.sv | 31 +++
 rtl/vrc_reg_decode.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vrc_pkg.sv
// Shared types and address-line unswizzling for the VRC2/4/6 register front-end.
// Mapper constants and the index decode are reused by the register bank and IRQ counter.
package vrc_pkg;

  typedef enum logic {
    IDLE,
    HIGH
  } state_e;

  localparam logic [7:0] MAP_VRC21 = 8'd21;
  localparam logic [7:0] MAP_VRC22 = 8'd22;
  localparam logic [7:0] MAP_VRC23 = 8'd23;
  localparam logic [7:0] MAP_VRC24 = 8'd24;
  localparam logic [7:0] MAP_VRC25 = 8'd25;
  localparam logic [7:0] MAP_VRC26 = 8'd26;

  // Each board wires different CPU address lines to the register select.
  function automatic logic [1:0] vrc_idx(
    input logic [7:0]  map_idx,
    input logic [15:0] a
  );
    logic hi;
    logic lo;
    hi = a[1];
    lo = a[0];
    unique case (map_idx)
      MAP_VRC21: begin
        hi = a[2] | a[7];
        lo = a[1] | a[6];
      end
      MAP_VRC22: begin
        hi = a[0];
        lo = a[1];
      end
      MAP_VRC23: begin
        hi = a[1] | a[3];
        lo = a[0] | a[2];
      end
      MAP_VRC24: begin
        hi = a[1];
        lo = a[0];
      end
      MAP_VRC25: begin
        hi = a[0] | a[2];
        lo = a[1] | a[3];
      end
      MAP_VRC26: begin
        hi = a[0];
        lo = a[1];
      end
      default: begin
        hi = a[1];
        lo = a[0];
      end
    endcase
    return {hi, lo};
  endfunction

endpackage

// File: rtl/vrc_reg_decode_m2_sync.sv
// M2 synchroniser into the clk domain with single-cycle rise/fall pulses.
// The edge pulses are combinational from the last two synchronised samples.
module m2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m2_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], m2_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/vrc_reg_decode.sv
// CPU bus front-end: qualifies M2 cycles and turns writes to $8000-$FFFF
// into canonical $X000..$X003 register writes with a one-cycle strobe.
module vrc_reg_decode #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4,
  parameter int DATA_DLY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rw,
  input  logic [7:0]  map_idx,
  input  logic        map_rst,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_data,
  output logic        reg_we,
  output logic        m2_rise
);

  import vrc_pkg::*;

  localparam logic [3:0] MIN_C = 4'(MIN_HIGH);
  localparam logic [3:0] DLY_C = 4'(DATA_DLY);

  logic s_sync;
  logic s_rise;
  logic s_fall;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sh_addr_q, sh_addr_d;
  logic [7:0]  sh_data_q, sh_data_d;
  logic        sh_rw_q, sh_rw_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        reg_we_q, reg_we_d;
  logic        rise_q, rise_d;

  m2_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .m2_i  (m2),
    .sync_o(s_sync),
    .rise_o(s_rise),
    .fall_o(s_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_addr_d  = sh_addr_q;
    sh_data_d  = sh_data_q;
    sh_rw_d    = sh_rw_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_we_d   = 1'b0;
    rise_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_rise) begin
          state_d = HIGH;
          cnt_d   = 4'd0;
          rise_d  = 1'b1;
          // Stale shadow must never look like a write.
          sh_rw_d = 1'b1;
        end
      end
      HIGH: begin
        if (s_fall) begin
          state_d = IDLE;
          if (cnt_q >= MIN_C && !sh_rw_q && sh_addr_q[15]) begin
            reg_we_d   = 1'b1;
            reg_addr_d = {sh_addr_q[15:12], 10'b0,
                          vrc_idx(map_idx, sh_addr_q)};
            reg_data_d = sh_data_q;
          end
        end else begin
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          if (cnt_q == DLY_C) begin
            sh_addr_d = cpu_addr;
            sh_data_d = cpu_data;
            sh_rw_d   = cpu_rw;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_addr_q  <= 16'h0000;
      sh_data_q  <= 8'h00;
      sh_rw_q    <= 1'b1;
      reg_addr_q <= 16'h0000;
      reg_data_q <= 8'h00;
      reg_we_q   <= 1'b0;
      rise_q     <= 1'b0;
    end else if (map_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_addr_q  <= 16'h0000;
      sh_data_q  <= 8'h00;
      sh_rw_q    <= 1'b1;
      reg_addr_q <= 16'h0000;
      reg_data_q <= 8'h00;
      reg_we_q   <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_addr_q  <= sh_addr_d;
      sh_data_q  <= sh_data_d;
      sh_rw_q    <= sh_rw_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_we_q   <= reg_we_d;
      rise_q     <= rise_d;
    end
  end

  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign reg_we   = reg_we_q;
  assign m2_rise  = rise_q;

endmodule
